// File: rtl/clock_pkg.sv
// Shared definitions for the clock design: state encoding, field limits and widths.
package clock_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_SET_HOUR = 2'd1,
    ST_SET_MIN  = 2'd2,
    ST_SET_SEC  = 2'd3
  } state_t;

  localparam int HOUR_W      = 5;
  localparam int MIN_SEC_W   = 6;
  localparam int HOUR_MAX    = 23;
  localparam int MIN_SEC_MAX = 59;

  // Any state other than RUN is a setting state.
  function automatic logic is_set_state(state_t s);
    return s != ST_RUN;
  endfunction

endpackage

// File: rtl/wrap_counter.sv
// Modulo-(MAX+1) up/down counter for one time field.
// inc and dec together cancel; carry flags an increment that wraps MAX back to 0.
module wrap_counter #(
  parameter int WIDTH = 6,
  parameter int MAX   = 59
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr,
  output logic [WIDTH-1:0] value,
  output logic             carry
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);

  // Wrap indication is combinational so a carry chain settles within one edge.
  assign carry = inc && (value == MAX_V);

  // Field register: clear wins, then a lone inc or a lone dec with wrap-around.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (inc && !dec) begin
      value <= (value == MAX_V) ? '0 : value + ONE_V;
    end else if (dec && !inc) begin
      value <= (value == '0) ? MAX_V : value - ONE_V;
    end
  end

endmodule

// File: rtl/time_set_ctrl.sv
// Timekeeping and time-setting controller between the key debouncers and the display.
//
// state       | meaning
// ST_RUN      | time advances on each prescaler wrap, tick_o pulses, blink_o held 1
// ST_SET_HOUR | INC/DEC adjust hours, time frozen, selected field blinks
// ST_SET_MIN  | INC/DEC adjust minutes, time frozen, selected field blinks
// ST_SET_SEC  | INC/DEC adjust seconds, time frozen, selected field blinks
module time_set_ctrl
  import clock_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int TICK_MAX  = 49_999_999,
  parameter int BLINK_MAX = 12_499_999,
  parameter int TIMEOUT_S = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 key_mode,
  input  logic                 key_inc,
  input  logic                 key_dec,
  output logic [HOUR_W-1:0]    hour_o,
  output logic [MIN_SEC_W-1:0] min_o,
  output logic [MIN_SEC_W-1:0] sec_o,
  output logic [1:0]           mode_o,
  output logic                 blink_o,
  output logic                 tick_o
);

  localparam int PRESC_W = (TICK_MAX > 0) ? $clog2(TICK_MAX + 1) : 1;
  localparam int BLINK_W = (BLINK_MAX > 0) ? $clog2(BLINK_MAX + 1) : 1;
  localparam int IDLE_W  = (TIMEOUT_S > 0) ? $clog2(TIMEOUT_S + 1) : 1;

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_MAX);
  localparam logic [PRESC_W-1:0] PRESC_ONE  = PRESC_W'(1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_MAX);
  localparam logic [BLINK_W-1:0] BLINK_ONE  = BLINK_W'(1);
  localparam logic [IDLE_W-1:0]  IDLE_LAST  = IDLE_W'(TIMEOUT_S);
  localparam logic [IDLE_W-1:0]  IDLE_ONE   = IDLE_W'(1);

  // CLK_FREQ only documents the intended clock; reject nonsense values at elaboration.
  if (CLK_FREQ <= 0) begin : g_clk_freq_check
    $error("time_set_ctrl: CLK_FREQ must be positive");
  end

  state_t               state;
  state_t               state_nxt;
  logic [PRESC_W-1:0]   presc;
  logic [BLINK_W-1:0]   blink_cnt;
  logic [IDLE_W-1:0]    idle_cnt;
  logic                 blink_q;
  logic                 tick_q;

  logic sec_evt;
  logic key_any;
  logic edit_inc;
  logic edit_dec;
  logic edit_accept;
  logic run_adv;
  logic timeout;
  logic enter_run;
  logic enter_set;

  logic hour_inc, hour_dec;
  logic min_inc,  min_dec;
  logic sec_inc,  sec_dec;
  logic sec_carry, min_carry;
  logic hour_carry_unused;

  assign sec_evt  = (presc == PRESC_LAST);
  assign key_any  = key_mode | key_inc | key_dec;
  // MODE pre-empts inc/dec; inc and dec together cancel out.
  assign edit_inc = key_inc & ~key_dec & ~key_mode;
  assign edit_dec = key_dec & ~key_inc & ~key_mode;
  assign edit_accept = is_set_state(state) & (edit_inc | edit_dec);
  assign run_adv  = (state == ST_RUN) & sec_evt;
  assign timeout  = (idle_cnt == IDLE_LAST);
  assign enter_run = is_set_state(state) & (state_nxt == ST_RUN);
  assign enter_set = is_set_state(state_nxt) & (state_nxt != state);

  // Field controls. Carries only ripple while running, so edits never spill over.
  assign sec_inc  = run_adv | ((state == ST_SET_SEC) & edit_inc);
  assign sec_dec  = (state == ST_SET_SEC) & edit_dec;
  assign min_inc  = ((state == ST_RUN) & sec_carry) | ((state == ST_SET_MIN) & edit_inc);
  assign min_dec  = (state == ST_SET_MIN) & edit_dec;
  assign hour_inc = ((state == ST_RUN) & min_carry) | ((state == ST_SET_HOUR) & edit_inc);
  assign hour_dec = (state == ST_SET_HOUR) & edit_dec;

  wrap_counter #(.WIDTH(MIN_SEC_W), .MAX(MIN_SEC_MAX)) u_sec (
    .clk   (clk),
    .rst   (rst),
    .inc   (sec_inc),
    .dec   (sec_dec),
    .clr   (1'b0),
    .value (sec_o),
    .carry (sec_carry)
  );

  wrap_counter #(.WIDTH(MIN_SEC_W), .MAX(MIN_SEC_MAX)) u_min (
    .clk   (clk),
    .rst   (rst),
    .inc   (min_inc),
    .dec   (min_dec),
    .clr   (1'b0),
    .value (min_o),
    .carry (min_carry)
  );

  // Day rollover is not tracked, so the hour carry goes nowhere.
  wrap_counter #(.WIDTH(HOUR_W), .MAX(HOUR_MAX)) u_hour (
    .clk   (clk),
    .rst   (rst),
    .inc   (hour_inc),
    .dec   (hour_dec),
    .clr   (1'b0),
    .value (hour_o),
    .carry (hour_carry_unused)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: MODE steps through the fields; an idle SET state falls back to RUN.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN: begin
        if (key_mode) state_nxt = ST_SET_HOUR;
      end
      ST_SET_HOUR: begin
        if (key_mode)                  state_nxt = ST_SET_MIN;
        else if (timeout && !key_any)  state_nxt = ST_RUN;
      end
      ST_SET_MIN: begin
        if (key_mode)                  state_nxt = ST_SET_SEC;
        else if (timeout && !key_any)  state_nxt = ST_RUN;
      end
      ST_SET_SEC: begin
        if (key_mode)                  state_nxt = ST_RUN;
        else if (timeout && !key_any)  state_nxt = ST_RUN;
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  // One-second prescaler; restarts on every return to RUN so a full second follows.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc <= '0;
    end else if (enter_run || sec_evt) begin
      presc <= '0;
    end else begin
      presc <= presc + PRESC_ONE;
    end
  end

  // Idle seconds while setting; any key or a new SET state restarts the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idle_cnt <= '0;
    end else if ((state == ST_RUN) || enter_set || key_any) begin
      idle_cnt <= '0;
    end else if (sec_evt && (idle_cnt != IDLE_LAST)) begin
      idle_cnt <= idle_cnt + IDLE_ONE;
    end
  end

  // Blink phase: solid while running, restarted visible on entry or after an edit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink_cnt <= '0;
      blink_q   <= 1'b1;
    end else if ((state_nxt == ST_RUN) || enter_set || edit_accept) begin
      blink_cnt <= '0;
      blink_q   <= 1'b1;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt <= '0;
      blink_q   <= ~blink_q;
    end else begin
      blink_cnt <= blink_cnt + BLINK_ONE;
    end
  end

  // Tick marks the cycle in which the advanced seconds value appears.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_q <= 1'b0;
    end else begin
      tick_q <= run_adv;
    end
  end

  assign mode_o  = state;
  assign blink_o = blink_q;
  assign tick_o  = tick_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Scoreboard bench for time_set_ctrl with a fast prescaler (10 cycles per second).
module tb_time_set_ctrl;

  localparam int F_HOUR  = 0;
  localparam int F_MIN   = 1;
  localparam int F_SEC   = 2;
  localparam int F_MODE  = 3;
  localparam int F_BLINK = 4;
  localparam int F_TICK  = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       key_mode = 1'b0;
  logic       key_inc  = 1'b0;
  logic       key_dec  = 1'b0;
  logic [4:0] hour_o;
  logic [5:0] min_o;
  logic [5:0] sec_o;
  logic [1:0] mode_o;
  logic       blink_o;
  logic       tick_o;

  typedef struct {
    int    cyc;
    string name;
    int    sel;
    int    val;
  } exp_t;

  typedef struct {
    int cyc;
    int h;
    int m;
    int s;
  } tick_t;

  exp_t  exp_q[$];
  tick_t tick_q[$];
  exp_t  mon_e;
  tick_t mon_t;
  int    cyc_cnt = 0;
  int    checks  = 0;
  int    errors  = 0;

  time_set_ctrl #(
    .CLK_FREQ  (100),
    .TICK_MAX  (9),
    .BLINK_MAX (3),
    .TIMEOUT_S (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .key_mode (key_mode),
    .key_inc  (key_inc),
    .key_dec  (key_dec),
    .hour_o   (hour_o),
    .min_o    (min_o),
    .sec_o    (sec_o),
    .mode_o   (mode_o),
    .blink_o  (blink_o),
    .tick_o   (tick_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  function automatic int field_val(int sel);
    case (sel)
      F_HOUR:  return int'(hour_o);
      F_MIN:   return int'(min_o);
      F_SEC:   return int'(sec_o);
      F_MODE:  return int'(mode_o);
      F_BLINK: return int'(blink_o);
      default: return int'(tick_o);
    endcase
  endfunction

  // Expected-value monitor: retires every queued expectation due in this cycle.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc_cnt) begin
      mon_e = exp_q.pop_front();
      checks++;
      if (mon_e.cyc != cyc_cnt) begin
        errors++;
        $display("FAIL %s: not checked at cycle %0d (now %0d)", mon_e.name, mon_e.cyc, cyc_cnt);
      end else if (field_val(mon_e.sel) != mon_e.val) begin
        errors++;
        $display("FAIL %s: cycle %0d got %0d expected %0d", mon_e.name, cyc_cnt,
                 field_val(mon_e.sel), mon_e.val);
      end
    end
    if (tick_o) begin
      checks++;
      if (tick_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_tick: cycle %0d time %0d:%0d:%0d", cyc_cnt, hour_o, min_o, sec_o);
      end else begin
        mon_t = tick_q.pop_front();
        if (mon_t.cyc != cyc_cnt || int'(hour_o) != mon_t.h || int'(min_o) != mon_t.m ||
            int'(sec_o) != mon_t.s) begin
          errors++;
          $display("FAIL tick: got cycle %0d time %0d:%0d:%0d expected cycle %0d time %0d:%0d:%0d",
                   cyc_cnt, hour_o, min_o, sec_o, mon_t.cyc, mon_t.h, mon_t.m, mon_t.s);
        end
      end
    end
  end

  task automatic expect_at(input int k, input string name, input int sel, input int val);
    exp_t e;
    e.cyc  = cyc_cnt + k;
    e.name = name;
    e.sel  = sel;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic expect_tick(input int k, input int h, input int m, input int s);
    tick_t t;
    t.cyc = cyc_cnt + k;
    t.h   = h;
    t.m   = m;
    t.s   = s;
    tick_q.push_back(t);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One-cycle key pulse sampled by the next rising edge, followed by one idle cycle.
  task automatic pulse(input logic m, input logic i, input logic d);
    key_mode = m;
    key_inc  = i;
    key_dec  = d;
    @(negedge clk);
    key_mode = 1'b0;
    key_inc  = 1'b0;
    key_dec  = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    step(5);

    // Reset values and the first second after release.
    expect_at(1, "rst_hour", F_HOUR, 0);
    expect_at(1, "rst_min", F_MIN, 0);
    expect_at(1, "rst_sec", F_SEC, 0);
    expect_at(1, "rst_mode", F_MODE, 0);
    expect_at(1, "rst_blink", F_BLINK, 1);
    expect_at(1, "rst_tick", F_TICK, 0);
    expect_at(5, "run_blink", F_BLINK, 1);
    expect_at(9, "pre_tick_sec", F_SEC, 0);
    expect_at(9, "pre_tick_tick", F_TICK, 0);
    expect_at(10, "first_sec", F_SEC, 1);
    expect_tick(10, 0, 0, 1);
    rst = 1'b1;
    step(10);

    // SET_HOUR, decrement wraps 0 to 23.
    expect_at(1, "mode_set_hour", F_MODE, 1);
    expect_at(1, "sec_frozen_a", F_SEC, 1);
    pulse(1'b1, 1'b0, 1'b0);
    expect_at(1, "hour_dec_wrap", F_HOUR, 23);
    pulse(1'b0, 1'b0, 1'b1);

    // SET_MIN, 61 increments wrap to 1 with no carry into hours.
    expect_at(1, "mode_set_min", F_MODE, 2);
    pulse(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 61; i++) begin
      if (i == 60) begin
        expect_at(1, "min_inc61", F_MIN, 1);
        expect_at(1, "hour_no_carry", F_HOUR, 23);
        expect_at(1, "sec_frozen_b", F_SEC, 1);
      end
      pulse(1'b0, 1'b1, 1'b0);
    end
    pulse(1'b0, 1'b0, 1'b1);
    expect_at(1, "min_dec_wrap", F_MIN, 59);
    pulse(1'b0, 1'b0, 1'b1);

    // SET_SEC down to 58 through the 0 -> 59 wrap.
    expect_at(1, "mode_set_sec", F_MODE, 3);
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b1);
    pulse(1'b0, 1'b0, 1'b1);
    expect_at(1, "sec_dec_58", F_SEC, 58);
    pulse(1'b0, 1'b0, 1'b1);

    // Back to RUN at 23:59:58; first tick a full second later, then midnight rollover.
    expect_at(1, "mode_run", F_MODE, 0);
    expect_at(1, "preset_hour", F_HOUR, 23);
    expect_at(1, "preset_min", F_MIN, 59);
    expect_at(10, "run_entry_sec", F_SEC, 58);
    expect_at(10, "run_entry_tick", F_TICK, 0);
    expect_at(11, "roll_sec59", F_SEC, 59);
    expect_at(20, "hold_sec59", F_SEC, 59);
    expect_at(21, "roll_hour", F_HOUR, 0);
    expect_at(21, "roll_min", F_MIN, 0);
    expect_at(21, "roll_sec", F_SEC, 0);
    expect_tick(11, 23, 59, 59);
    expect_tick(21, 0, 0, 0);
    pulse(1'b1, 1'b0, 1'b0);
    step(19);

    // Idle timeout with no keys: exit right after the second idle second.
    expect_at(1, "to_enter", F_MODE, 1);
    expect_at(20, "to_hold", F_MODE, 1);
    expect_at(21, "to_exit", F_MODE, 0);
    expect_at(21, "to_sec_frozen", F_SEC, 0);
    pulse(1'b1, 1'b0, 1'b0);
    step(19);

    // Timeout restarted by a key 15 cycles after entry.
    expect_at(1, "to2_enter", F_MODE, 1);
    pulse(1'b1, 1'b0, 1'b0);
    step(13);
    expect_at(1, "to2_hour_inc", F_HOUR, 1);
    expect_at(6, "to2_not_yet", F_MODE, 1);
    expect_at(15, "to2_hold", F_MODE, 1);
    expect_at(16, "to2_exit", F_MODE, 0);
    pulse(1'b0, 1'b1, 1'b0);
    step(14);

    // Simultaneous keys in SET_MIN.
    pulse(1'b1, 1'b0, 1'b0);
    expect_at(1, "sim_set_min", F_MODE, 2);
    pulse(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      if (i == 4) expect_at(1, "sim_min5", F_MIN, 5);
      pulse(1'b0, 1'b1, 1'b0);
    end
    expect_at(1, "incdec_min", F_MIN, 5);
    expect_at(1, "incdec_mode", F_MODE, 2);
    expect_at(1, "incdec_hour", F_HOUR, 1);
    pulse(1'b0, 1'b1, 1'b1);
    step(4);

    // MODE beats INC; SET_SEC entry starts the 8-cycle blink with 4 visible cycles.
    expect_at(1, "modeinc_mode", F_MODE, 3);
    expect_at(1, "modeinc_min", F_MIN, 5);
    expect_at(1, "modeinc_sec", F_SEC, 0);
    for (int k = 1; k <= 13; k++) begin
      expect_at(k, $sformatf("blink_k%0d", k), F_BLINK, ((k - 1) % 8 < 4) ? 1 : 0);
    end
    pulse(1'b1, 1'b1, 1'b0);
    step(11);

    // INC in the low phase forces the field visible and restarts the blink count.
    expect_at(1, "edit_sec", F_SEC, 1);
    for (int j = 1; j <= 5; j++) begin
      expect_at(j, $sformatf("edit_blink_j%0d", j), F_BLINK, (j <= 4) ? 1 : 0);
    end
    pulse(1'b0, 1'b1, 1'b0);
    step(4);

    // Reset mid-setting drops the partial time immediately.
    expect_at(1, "mid_rst_hour", F_HOUR, 0);
    expect_at(1, "mid_rst_min", F_MIN, 0);
    expect_at(1, "mid_rst_sec", F_SEC, 0);
    expect_at(1, "mid_rst_mode", F_MODE, 0);
    expect_at(1, "mid_rst_blink", F_BLINK, 1);
    rst = 1'b0;
    step(3);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL exp_queue_drain: %0d expectations left, required 0", exp_q.size());
    end
    checks++;
    if (tick_q.size() != 0) begin
      errors++;
      $display("FAIL tick_queue_drain: %0d ticks missing, required 0", tick_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
